switch_debounce_3ch: RTL
========================

// Module: switch_debounce_3ch
// PURPOSE
//  Upstream input stage for the 3-input LUT logic driving o_LED_1.
//  Synchronises the three raw board switches (A, B, C) into the clock domain.
//  Debounces each one independently and presents clean, stable levels to the LUT stage.
//  Also emits one-cycle rise/fall strobes per switch for future sequential consumers.
// PARAMETERS
//  DEBOUNCE_LIMIT  250000  consecutive mismatch cycles before a level is accepted
//                          (10 ms at 25 MHz). Must be >= 1; elaboration error otherwise.
//  SYNC_STAGES     2       synchroniser flop depth per switch. Must be >= 2.
// PORTS
//  i_Clk          in   1  system clock, all logic on posedge
//  i_Rst_L        in   1  asynchronous active-low reset
//  i_Switch_A     in   1  raw switch A (asynchronous, bouncy)
//  i_Switch_B     in   1  raw switch B
//  i_Switch_C     in   1  raw switch C
//  o_Switch_A     out  1  debounced switch A level
//  o_Switch_B     out  1  debounced switch B level
//  o_Switch_C     out  1  debounced switch C level
//  o_Switch_Rise  out  3  1-cycle strobe on debounced 0->1; bit0=A, bit1=B, bit2=C
//  o_Switch_Fall  out  3  1-cycle strobe on debounced 1->0; same bit order
// BEHAVIOUR
//  - Reset: i_Rst_L=0 asynchronously clears all state:
//    sync flops, counters, o_Switch_A/B/C, o_Switch_Rise and o_Switch_Fall all go to 0.
//    Deassertion is used as-is; no internal reset synchroniser.
//  - Per channel (3 identical, fully independent instances of this logic):
//    * Sync chain: SYNC_STAGES flops. "synced" is the last flop's output.
//    * Counter: width $clog2(DEBOUNCE_LIMIT+1), unsigned.
//    * Two states, determined by comparing synced with the registered debounced level:
//      STABLE   (synced == debounced): counter <= 0.
//      COUNTING (synced != debounced):
//        - If counter < DEBOUNCE_LIMIT-1: counter <= counter+1.
//        - If counter == DEBOUNCE_LIMIT-1: debounced <= synced, counter <= 0,
//          and the matching Rise/Fall bit is 1 for exactly the following cycle.
//    * Any return to the accepted level before the limit is reached (a bounce)
//      clears the counter. The count restarts from 0 on the next mismatch.
//      The counter never wraps or saturates past DEBOUNCE_LIMIT-1.
//  - Latency: a clean step sampled at edge 0 appears on o_Switch_X after edge
//    SYNC_STAGES+DEBOUNCE_LIMIT-1. The strobe is high in that same cycle only.
//  - Rise and Fall are registered and mutually exclusive per bit.
//    Strobes on different channels may coincide.
//  - Switch held high through reset release: the block treats it as a normal
//    0->1 transition, so o_Switch_X rises after the full latency and emits a Rise strobe.
//  - Reset asserted mid-count: the count is discarded; no strobe is emitted.
//  - All outputs are registered; there is no combinational path from input to output.
// TESTING (bench uses DEBOUNCE_LIMIT=4, SYNC_STAGES=2)
//  1. A: 0->1 step sampled at edge 0 -> o_Switch_A=1 after edge 5;
//     o_Switch_Rise=3'b001 for exactly that cycle; B and C stay 0.
//  2. B: 3-cycle high glitch -> o_Switch_B stays 0; no strobes.
//     Then a 4-cycle high pulse -> o_Switch_B rises, with one Rise strobe.
//  3. All three switches step together -> all outputs rise after the same edge;
//     o_Switch_Rise=3'b111 for 1 cycle. Then C alone falls -> o_Switch_Fall=3'b100 only.
//  4. Bounce pattern on A (1,0,1,1,0,1,1,1,1) -> exactly one Rise strobe,
//     4 cycles after the final sync'd 1 run begins.
//  5. i_Rst_L pulsed low when A's counter is at 2 -> all outputs 0 immediately,
//     no strobe. With A held high, o_Switch_A rises 5 edges after release.
//  6. Random bouncy stimulus, 10k cycles, versus a reference model ->
//     every output change is preceded by DEBOUNCE_LIMIT stable synced cycles.

Source files
------------

// File: rtl/switch_debounce_3ch.sv
// Three-channel switch conditioner: synchronise, debounce and edge-detect raw board switches.
// Each channel accepts a new level only after DEBOUNCE_LIMIT consecutive mismatching synced samples.
module switch_debounce_3ch #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Switch_A,
  input  logic       i_Switch_B,
  input  logic       i_Switch_C,
  output logic       o_Switch_A,
  output logic       o_Switch_B,
  output logic       o_Switch_C,
  output logic [2:0] o_Switch_Rise,
  output logic [2:0] o_Switch_Fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (DEBOUNCE_LIMIT < 1) begin : g_bad_limit
    $error("switch_debounce_3ch: DEBOUNCE_LIMIT must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("switch_debounce_3ch: SYNC_STAGES must be >= 2");
  end

  logic [2:0] w_raw;
  logic [2:0] w_deb;
  logic [2:0] w_rise;
  logic [2:0] w_fall;

  assign w_raw = {i_Switch_C, i_Switch_B, i_Switch_A};

  for (genvar g = 0; g < 3; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_deb;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_synced;

    assign w_synced = r_sync[SYNC_STAGES-1];

    // Any sample matching the accepted level restarts the qualification window.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        r_sync <= '0;
        r_cnt  <= '0;
        r_deb  <= 1'b0;
        r_rise <= 1'b0;
        r_fall <= 1'b0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[g]};
        r_rise <= 1'b0;
        r_fall <= 1'b0;
        if (w_synced == r_deb) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
          r_deb  <= w_synced;
          r_cnt  <= '0;
          r_rise <= w_synced;
          r_fall <= ~w_synced;
        end else begin
          r_cnt <= r_cnt + CNT_ONE;
        end
      end
    end

    assign w_deb[g]  = r_deb;
    assign w_rise[g] = r_rise;
    assign w_fall[g] = r_fall;
  end

  assign o_Switch_A    = w_deb[0];
  assign o_Switch_B    = w_deb[1];
  assign o_Switch_C    = w_deb[2];
  assign o_Switch_Rise = w_rise;
  assign o_Switch_Fall = w_fall;

endmodule
